// File: rtl/sha256_pkg.sv
// sha256_pkg: register map, status layout, FSM encoding, FIPS 180-4 constants and helpers.
package sha256_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_FINAL = 2'd3
    } sha_state_e;

    // Register map on the low 8 address bits.
    localparam logic [7:0] MSG_BASE = 8'h00;  // 0x00-0x0F message words M[0..15]
    localparam logic [7:0] DIG_BASE = 8'h10;  // 0x10-0x17 digest words H[0..7]
    localparam logic [7:0] CMD      = 8'h20;  // command register

    // Status word bit positions.
    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ACK     = 2;
    localparam int ST_ERR     = 3;
    localparam int ST_CNT_LSB = 8;

    // Command register bits.
    localparam int CMD_INIT    = 0;
    localparam int CMD_START   = 1;
    localparam int CMD_CLR_ERR = 2;

    localparam logic [5:0] LAST_ROUND = 6'd63;

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] Sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] Sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] Ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] Maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 round; element 0 of the state is 'a', element 7 is 'h'.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [7:0][31:0] st_i,
    input  logic [31:0]      w_i,
    input  logic [31:0]      k_i,
    output logic [7:0][31:0] st_o
);

    logic [31:0] t1;
    logic [31:0] t2;

    assign t1 = st_i[7] + Sigma1(st_i[4]) + Ch(st_i[4], st_i[5], st_i[6]) + k_i + w_i;
    assign t2 = Sigma0(st_i[0]) + Maj(st_i[0], st_i[1], st_i[2]);

    assign st_o[0] = t1 + t2;
    assign st_o[1] = st_i[0];
    assign st_o[2] = st_i[1];
    assign st_o[3] = st_i[2];
    assign st_o[4] = st_i[3] + t1;
    assign st_o[5] = st_i[4];
    assign st_o[6] = st_i[5];
    assign st_o[7] = st_i[6];

endmodule

// File: rtl/sha256_pio_engine.sv
// sha256_pio_engine: PIO-driven SHA-256 block engine (one round per cycle, 66-cycle block).
//
// Command handshake: a command is valid in exactly the cycle where
// sha_addr_export[31] differs from last_tog; it is always accepted (there is
// no back-pressure), and the status ack bit mirrors last_tog so software sees
// the toggle echoed once the command has been taken.
module sha256_pio_engine
    import sha256_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [31:0] sha_dout_export,
    input  logic [31:0] sha_addr_export,
    output logic [31:0] sha_din_export,
    output logic [31:0] sha_status_export
);

    sha_state_e state_q, state_d;

    logic             last_tog_q;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      din_q;
    logic [7:0][31:0] h_q, h_d;
    logic [15:0][31:0] m_q;
    logic [7:0][31:0] work_q;     // a..h working registers
    logic [15:0][31:0] w_q;       // schedule window, w_q[0] = W_t
    logic [5:0]       rnd_q;

    logic [7:0][31:0] work_next;
    logic [31:0]      w_new;

    logic [7:0] addr;
    logic       cmd_valid, is_msg, is_dig, is_cmd;
    logic       busy, load_en, round_en, final_en;
    logic       msg_wr, rd_dig, do_init, do_start, clr_err, viol;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^sha_addr_export[30:8];

    // Command decode: qualify each action with the toggle and the busy state.
    assign addr      = sha_addr_export[7:0];
    assign cmd_valid = sha_addr_export[31] ^ last_tog_q;
    assign is_msg    = (addr[7:4] == MSG_BASE[7:4]);
    assign is_dig    = (addr[7:3] == DIG_BASE[7:3]);
    assign is_cmd    = (addr == CMD);
    assign msg_wr    = cmd_valid & is_msg & ~busy;
    assign rd_dig    = cmd_valid & is_dig;
    assign do_init   = cmd_valid & is_cmd & sha_dout_export[CMD_INIT] & ~busy;
    assign do_start  = cmd_valid & is_cmd & sha_dout_export[CMD_START] & ~busy;
    assign clr_err   = cmd_valid & is_cmd & sha_dout_export[CMD_CLR_ERR];
    assign viol      = cmd_valid & busy &
                       (is_msg | (is_cmd & (sha_dout_export[CMD_INIT] | sha_dout_export[CMD_START])));

    // FSM state register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state_q <= S_IDLE;
        else                state_q <= state_d;
    end

    // FSM next state: LOAD and FINAL are single cycles, ROUND runs t = 0..63.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (do_start) state_d = S_LOAD;
            S_LOAD:  state_d = S_ROUND;
            S_ROUND: if (rnd_q == LAST_ROUND) state_d = S_FINAL;
            S_FINAL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy covers LOAD, ROUND and FINAL.
    always_comb begin
        busy     = 1'b1;
        load_en  = 1'b0;
        round_en = 1'b0;
        final_en = 1'b0;
        case (state_q)
            S_IDLE:  busy     = 1'b0;
            S_LOAD:  load_en  = 1'b1;
            S_ROUND: round_en = 1'b1;
            S_FINAL: final_en = 1'b1;
            default: busy     = 1'b0;
        endcase
    end

    // Next values of digest, counter and flags; error set wins over a same-cycle clear.
    always_comb begin
        err_d   = err_q;
        done_d  = done_q;
        count_d = count_q;
        h_d     = h_q;
        if (clr_err) err_d = 1'b0;
        if (viol)    err_d = 1'b1;
        if (do_init) begin
            done_d  = 1'b0;
            count_d = '0;
            for (int i = 0; i < 8; i++) h_d[i] = IV[i];
        end
        if (load_en) done_d = 1'b0;
        if (final_en) begin
            done_d  = 1'b1;
            count_d = count_q + CNT_W'(1);
            for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + work_q[i];
        end
    end

    // Control registers, digest, message store and read-data register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            last_tog_q <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            din_q      <= '0;
            m_q        <= '0;
            for (int i = 0; i < 8; i++) h_q[i] <= IV[i];
        end else begin
            // Tracking addr[31] every cycle is the same as updating it on a toggle.
            last_tog_q <= sha_addr_export[31];
            err_q      <= err_d;
            done_q     <= done_d;
            count_q    <= count_d;
            h_q        <= h_d;
            if (msg_wr) m_q[addr[3:0]] <= sha_dout_export;
            if (rd_dig) din_q <= h_q[addr[2:0]];
        end
    end

    // Next schedule word W_{t+16} from the window W_t..W_{t+15}.
    assign w_new = sigma1(w_q[14]) + w_q[9] + sigma0(w_q[1]) + w_q[0];

    sha256_round u_round (
        .st_i (work_q),
        .w_i  (w_q[0]),
        .k_i  (K[rnd_q]),
        .st_o (work_next)
    );

    // Working registers, schedule window and round counter; M is only read here.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            work_q <= '0;
            w_q    <= '0;
            rnd_q  <= '0;
        end else if (load_en) begin
            work_q <= h_q;
            w_q    <= m_q;
            rnd_q  <= '0;
        end else if (round_en) begin
            work_q <= work_next;
            w_q    <= {w_new, w_q[15:1]};
            rnd_q  <= rnd_q + 6'd1;
        end
    end

    // Status word assembly.
    always_comb begin
        sha_status_export                          = '0;
        sha_status_export[ST_BUSY]                 = busy;
        sha_status_export[ST_DONE]                 = done_q;
        sha_status_export[ST_ACK]                  = last_tog_q;
        sha_status_export[ST_ERR]                  = err_q;
        sha_status_export[ST_CNT_LSB +: CNT_W]     = count_q;
    end

    assign sha_din_export = din_q;

endmodule

// File: tb/tb_sha256_pio_engine.sv
// tb_sha256_pio_engine: randomized PIO command stimulus against a behavioural SHA-256 engine model.
module tb_sha256_pio_engine;

    localparam int CNT_W = 8;
    localparam int BLOCK_CYCLES = 66;

    localparam logic [31:0] KC [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IVC [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    logic        clk;
    logic        rst_n;
    logic [31:0] sha_dout;
    logic [31:0] sha_addr;
    logic [31:0] sha_din;
    logic [31:0] sha_status;

    int   checks   = 0;
    int   failures = 0;
    logic tog;
    logic [31:0] blk_buf [16];

    // Model state
    logic [31:0]      m_h [8];
    logic [31:0]      m_msg [16];
    logic [31:0]      m_din;
    logic             m_tog, m_done, m_err;
    logic [CNT_W-1:0] m_count;
    int               m_left;   // busy cycles still to run

    sha256_pio_engine #(.CNT_W(CNT_W)) dut (
        .clk_clk           (clk),
        .reset_reset_n     (rst_n),
        .sha_dout_export   (sha_dout),
        .sha_addr_export   (sha_addr),
        .sha_din_export    (sha_din),
        .sha_status_export (sha_status)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Plain FIPS 180-4 compression of m_msg into m_h with a full 64-word schedule.
    function automatic void model_compress();
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = m_msg[t];
            else begin
                s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = s1 + w[t-7] + s0 + w[t-16];
            end
        end
        for (int i = 0; i < 8; i++) v[i] = m_h[i];
        for (int t = 0; t < 64; t++) begin
            s1 = ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25);
            t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KC[t] + w[t];
            s0 = ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22);
            t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) m_h[i] = m_h[i] + v[i];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++)  m_h[i] = IVC[i];
        for (int i = 0; i < 16; i++) m_msg[i] = '0;
        m_din = '0; m_tog = 1'b0; m_done = 1'b0; m_err = 1'b0;
        m_count = '0; m_left = 0;
    endfunction

    // One clock edge of the engine as seen by software.
    function automatic void model_step();
        logic [7:0] a;
        logic       busy_pre, start_now;
        a         = sha_addr[7:0];
        busy_pre  = (m_left != 0);
        start_now = 1'b0;
        if (sha_addr[31] != m_tog) begin
            m_tog = sha_addr[31];
            if (a <= 8'h0f) begin
                if (busy_pre) m_err = 1'b1;
                else          m_msg[a[3:0]] = sha_dout;
            end else if (a <= 8'h17) begin
                m_din = m_h[a[2:0]];
            end else if (a == 8'h20) begin
                if (sha_dout[2]) m_err = 1'b0;
                if (busy_pre && (sha_dout[0] || sha_dout[1])) m_err = 1'b1;
                if (!busy_pre) begin
                    if (sha_dout[0]) begin
                        for (int i = 0; i < 8; i++) m_h[i] = IVC[i];
                        m_count = '0;
                        m_done  = 1'b0;
                    end
                    if (sha_dout[1]) start_now = 1'b1;
                end
            end
        end
        if (busy_pre) begin
            if (m_left == BLOCK_CYCLES) m_done = 1'b0;
            m_left = m_left - 1;
            if (m_left == 0) begin
                model_compress();
                m_done  = 1'b1;
                m_count = m_count + CNT_W'(1);
            end
        end
        if (start_now) m_left = BLOCK_CYCLES;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = '0;
        s[0] = (m_left != 0);
        s[1] = m_done;
        s[2] = m_tog;
        s[3] = m_err;
        s[8 +: CNT_W] = m_count;
        return s;
    endfunction

    // Model process
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Compare process
    initial begin
        forever begin
            @(negedge clk);
            chk("status", sha_status, exp_status());
            chk("din", sha_din, m_din);
        end
    end

    task automatic send(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        tog      = ~tog;
        sha_addr = {tog, 23'($urandom), a};
        sha_dout = d;
    endtask

    task automatic hold_change(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        sha_addr = {tog, 23'($urandom), a};
        sha_dout = d;
    endtask

    task automatic read_dig(input int idx, output logic [31:0] data);
        send(8'(8'h10 + idx), $urandom);
        @(posedge clk);
        @(negedge clk);
        data = sha_din;
    endtask

    task automatic load_block();
        for (int i = 0; i < 16; i++) send(8'(i), blk_buf[i]);
    endtask

    task automatic wait_idle();
        @(posedge clk); #1;
        for (int i = 0; i < 200 && m_left != 0; i++) @(negedge clk);
        checks++;
        if (m_left != 0) begin
            failures++;
            $display("FAIL wait_idle left=%0d exp=0", m_left);
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk_buf[i] = '0;
        blk_buf[0]  = 32'h61626380;
        blk_buf[15] = 32'h00000018;
    endtask

    // Main stimulus
    initial begin
        logic [31:0] rd;
        int n;
        rst_n = 1'b0; sha_addr = '0; sha_dout = '0; tog = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_status", sha_status, 32'h0);
        chk("rst_din", sha_din, 32'h0);
        rst_n = 1'b1;
        read_dig(0, rd);
        chk("iv_h0", rd, 32'h6a09e667);

        // "abc" single block with busy length
        send(8'h20, 32'h1);
        set_abc();
        load_block();
        send(8'h20, 32'h2);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sha_status[0]) n++;
            else if (n > 0) break;
        end
        chk("busy_cycles", 32'(n), 32'd66);
        chk("abc_status", sha_status, 32'h00000102 | {29'b0, tog, 2'b0});
        read_dig(0, rd); chk("abc_h0", rd, 32'hba7816bf);
        read_dig(7, rd); chk("abc_h7", rd, 32'hf20015ad);

        // Illegal actions while busy
        send(8'h20, 32'h1);
        load_block();
        send(8'h20, 32'h2);
        repeat (5) @(posedge clk);
        send(8'h03, 32'hdeadbeef);
        send(8'h20, 32'h1);
        @(posedge clk); @(negedge clk);
        chk("busy_err", {31'b0, sha_status[3]}, 32'h1);
        wait_idle();
        read_dig(0, rd); chk("busy_h0", rd, 32'hba7816bf);
        read_dig(7, rd); chk("busy_h7", rd, 32'hf20015ad);
        send(8'h20, 32'h4);
        @(posedge clk); @(negedge clk);
        chk("err_clr", {31'b0, sha_status[3]}, 32'h0);

        // Two-block message
        send(8'h20, 32'h1);
        blk_buf = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        load_block();
        send(8'h20, 32'h2);
        wait_idle();
        for (int i = 0; i < 16; i++) blk_buf[i] = '0;
        blk_buf[15] = 32'h000001c0;
        load_block();
        send(8'h20, 32'h2);
        wait_idle();
        chk("two_cnt", {24'b0, sha_status[15:8]}, 32'd2);
        read_dig(0, rd); chk("two_h0", rd, 32'h248d6a61);
        read_dig(7, rd); chk("two_h7", rd, 32'h19db06c1);

        // Held toggle with new address/data does nothing
        hold_change(8'h20, 32'h3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("hold_cnt", {24'b0, sha_status[15:8]}, 32'd2);
        chk("hold_ack", {31'b0, sha_status[2]}, {31'b0, tog});
        chk("hold_busy", {31'b0, sha_status[0]}, 32'h0);

        // Combined init+start after a prior hash
        set_abc();
        load_block();
        send(8'h20, 32'h3);
        wait_idle();
        read_dig(0, rd); chk("is_h0", rd, 32'hba7816bf);
        chk("is_cnt", {24'b0, sha_status[15:8]}, 32'd1);

        // Randomized command traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: send(8'($urandom_range(0, 15)), $urandom);
                3, 4:    send(8'(8'h10 + $urandom_range(0, 7)), $urandom);
                5:       send(8'h20, 32'($urandom_range(0, 7)));
                6:       send(($urandom_range(0, 1) == 0) ? 8'(8'h18 + $urandom_range(0, 7))
                                                          : 8'($urandom_range(8'h21, 8'hff)), $urandom);
                7:       hold_change(8'($urandom), $urandom);
                default: repeat ($urandom_range(1, 20)) @(posedge clk);
            endcase
        end
        wait_idle();
        for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 1) == 1) send(8'h20, 32'h1);
            for (int i = 0; i < 16; i++) blk_buf[i] = $urandom;
            load_block();
            send(8'h20, 32'h2);
            wait_idle();
            for (int i = 0; i < 8; i++) read_dig(i, rd);
        end

        // Counter wrap: 257 blocks after init leaves count at 1
        send(8'h20, 32'h1);
        for (int i = 0; i < 16; i++) blk_buf[i] = $urandom;
        load_block();
        for (int i = 0; i < 257; i++) begin
            send(8'h20, 32'h2);
            wait_idle();
        end
        chk("cnt_wrap", {24'b0, sha_status[15:8]}, 32'd1);

        // Reset in the middle of round 30
        send(8'h20, 32'h1);
        set_abc();
        load_block();
        send(8'h20, 32'h2);
        repeat (32) @(posedge clk);
        #2;
        rst_n = 1'b0; tog = 1'b0; sha_addr = '0; sha_dout = '0;
        #1;
        chk("mid_rst_status", sha_status, 32'h0);
        chk("mid_rst_din", sha_din, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        read_dig(0, rd);
        chk("mid_rst_h0", rd, 32'h6a09e667);
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha256_pio_engine.md
SHA256_PIO_ENGINE -- requirements
Module: sha256_pio_engine

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning the width of the processed-block counter.
REQ-002 SHALL have port clk_clk  in  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port sha_dout_export  in  32  command/data word from the Nios PIO.
REQ-005 SHALL have port sha_addr_export  in  32  bit 31 is the command toggle; bits 7:0 are the register address.
REQ-006 SHALL have port sha_din_export  out  32  registered read-data to the Nios PIO.
REQ-007 SHALL have port sha_status_export  out  32  status word: [0] busy, [1] done, [2] ack, [3] err, [8+CNT_W-1:8] block count, all other bits 0.

Function
REQ-008 SHALL capture a command in the cycle where sha_addr_export[31] differs from the internal last_tog register, then set last_tog to the new value; status[2] SHALL equal last_tog.
REQ-009 SHALL treat a held toggle value as no command, regardless of any change in address or data.
REQ-010 SHALL, at address 0x00-0x0F when idle, write sha_dout_export into message word M[addr[3:0]].
REQ-011 SHALL, at address 0x10-0x17, load H[addr[2:0]] into sha_din_export one cycle after capture; this is also permitted while busy.
REQ-012 SHALL, at address 0x20, act on dout bits as follows: [0] init (H<=IV, count<=0, done<=0); [1] start; [2] clear err. When init and start are set together, init SHALL apply first and hashing SHALL start from the IV.
REQ-013 SHALL, for any other address, only acknowledge the command.
REQ-014 SHALL, on a message write, init or start while busy, ignore the action, still acknowledge, and set err (sticky).
REQ-015 SHALL implement the FSM IDLE -> LOAD (1 cycle: a..h<=H, W window<=M, done<=0) -> ROUND (64 cycles, t=0..63) -> FINAL (1 cycle: H[i]<=H[i]+reg) -> IDLE.
REQ-016 SHALL, in FINAL, set done=1 and increment count; count SHALL wrap from 2^CNT_W-1 to 0.
REQ-017 SHALL assert busy from the cycle after start capture until FINAL completes, i.e. 66 cycles of busy.
REQ-018 SHALL hold W in a 16-word sliding window: W_t = M_t for t<16; for t>=16, W_t = sigma1(W_{t-2}) + W_{t-7} + sigma0(W_{t-15}) + W_{t-16}.
REQ-019 SHALL perform all additions modulo 2^32.
REQ-020 SHALL use round logic per FIPS 180-4 SHA-256, with constant K_t indexed by the round counter.
REQ-021 SHALL leave M unmodified by hashing, so a restart rehashes the same block.
REQ-022 SHALL NOT perform padding; software supplies padded blocks.

Reset
REQ-023 SHALL, on reset assertion at any time, including mid-round, asynchronously force: FSM=IDLE, round counter=0, H=IV, M=0, a..h=0, last_tog=0, count=0, busy/done/err=0, sha_din_export=0, sha_status_export=0.
REQ-024 SHALL, after reset release, take the first command at the first toggle of addr[31] to 1.

Structure
REQ-025 SHALL place the following in shared package sha256_pkg: K[0:63], IV[0:7], state enum, address constants (MSG_BASE 0x00, DIG_BASE 0x10, CMD 0x20), status bit indices, and functions sigma0/sigma1/Sigma0/Sigma1/Ch/Maj.
REQ-026 SHALL put one round's combinational compute (a..h, W_t, K_t -> next a..h) in sub-module sha256_round; control, registers and the schedule SHALL stay in sha256_pio_engine.

Verification
REQ-027 Reset check: after reset -> status=0x00000000, sha_din=0; read addr 0x10 -> 0x6a09e667.
REQ-028 "abc" block: init; M0=0x61626380, M1..M14=0, M15=0x00000018; start -> busy 66 cycles, then done=1, count=1, H0=0xba7816bf, H7=0xf20015ad.
REQ-029 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": init, block1, start, wait, block2, start -> count=2, H0=0x248d6a61, H7=0x19db06c1.
REQ-030 Write to M3 and init during busy -> both ignored, ack toggles, err=1, final digest still equals the "abc" result; cmd 0x20 with dout=0x4 -> err=0.
REQ-031 Reset asserted at round 30 -> all status bits 0 immediately; after release, H0 reads 0x6a09e667.
REQ-032 Re-presenting the same toggle with a new address/data -> no action, ack unchanged; combined init+start (dout=0x3) after a prior hash -> digest equals the fresh single-block result.
